// File: rtl/display_driver.sv
// Converts an 8-bit value to three BCD digits with a sequential double-dabble engine
// and time-multiplexes them onto a common-cathode 7-segment display.
module display_driver #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  value,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [2:0]  anode,
    output logic [6:0]  seg
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  last_reg, last_next;
    logic [19:0] shift_reg, shift_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [11:0] bcd_reg, bcd_next;
    logic [15:0] presc_reg;
    logic [1:0]  digit_reg;

    logic [19:0] adjusted;
    logic [19:0] stepped;

    // Add-3 correction on each BCD nibble before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = shift_reg[8 + 4*gi +: 4];
            assign adjusted[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate
    assign adjusted[7:0] = shift_reg[7:0];
    assign stepped       = {adjusted[18:0], 1'b0};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            last_reg  <= 8'h00;
            shift_reg <= 20'h00000;
            cnt_reg   <= 3'd0;
            bcd_reg   <= 12'h000;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            bcd_reg   <= bcd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        bcd_next   = bcd_reg;
        case (state_reg)
            IDLE: begin
                if (value != last_reg) begin
                    last_next  = value;
                    shift_next = {12'h000, value};
                    cnt_next   = 3'd0;
                    state_next = CONV;
                end
            end
            CONV: begin
                shift_next = stepped;
                cnt_next   = cnt_reg + 3'd1;
                // Eighth step: the whole result is committed in one edge.
                if (cnt_reg == 3'd7) begin
                    bcd_next   = stepped[19:8];
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == CONV);
    assign bcd  = bcd_reg;

    // Scan prescaler and digit index run freely, independent of conversion.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_reg <= 16'd0;
            digit_reg <= 2'd0;
        end else if (presc_reg == 16'(SCAN_DIV - 1)) begin
            presc_reg <= 16'd0;
            digit_reg <= (digit_reg == 2'd2) ? 2'd0 : digit_reg + 2'd1;
        end else begin
            presc_reg <= presc_reg + 16'd1;
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    logic hund_zero;
    logic tens_zero;
    assign hund_zero = (bcd_reg[11:8] == 4'd0);
    assign tens_zero = (bcd_reg[7:4] == 4'd0);

    always_comb begin
        anode = 3'b000;
        seg   = 7'h00;
        case (digit_reg)
            2'd0: begin
                anode = 3'b001;
                seg   = decode(bcd_reg[3:0]);
            end
            2'd1: begin
                anode = 3'b010;
                seg   = (BLANK_LZ && hund_zero && tens_zero) ? 7'h00 : decode(bcd_reg[7:4]);
            end
            2'd2: begin
                anode = 3'b100;
                seg   = (BLANK_LZ && hund_zero) ? 7'h00 : decode(bcd_reg[11:8]);
            end
            default: begin
                anode = 3'b000;
                seg   = 7'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_display_driver.sv
// Directed bench for display_driver: table of values with expected BCD and per-slot
// segment patterns, plus sequences for mid-conversion change, abort and scan timing.
module tb_display_driver;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  value = 8'h00;

    logic        busy, busy_nb, busy_s1;
    logic [11:0] bcd, bcd_nb, bcd_s1;
    logic [2:0]  anode, anode_nb, anode_s1;
    logic [6:0]  seg, seg_nb, seg_s1;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .clr(clr), .value(value),
        .busy(busy), .bcd(bcd), .anode(anode), .seg(seg));

    display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .clr(clr), .value(value),
        .busy(busy_nb), .bcd(bcd_nb), .anode(anode_nb), .seg(seg_nb));

    display_driver #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) dut_s1 (
        .clk(clk), .clr(clr), .value(value),
        .busy(busy_s1), .bcd(bcd_s1), .anode(anode_s1), .seg(seg_s1));

    typedef struct {
        logic [7:0]  v;
        logic [11:0] b;
        logic [6:0]  s0, s1, s2;   // blanking instance: ones, tens, hundreds
        logic [6:0]  n0, n1, n2;   // no-blanking instance
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Apply a new value and count busy cycles; flags any bcd change before the commit.
    task automatic convert(input logic [7:0] v, output int nbusy, output int early);
        logic [11:0] old;
        old   = bcd;
        value = v;
        early = 0;
        @(negedge clk);
        nbusy = 0;
        while (busy && nbusy < 20) begin
            if (bcd !== old) early = 1;
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic capture_frame(output logic [6:0] m0, m1, m2, n0, n1, n2, output int busy_seen);
        m0 = 'x; m1 = 'x; m2 = 'x; n0 = 'x; n1 = 'x; n2 = 'x;
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
            case (anode)
                3'b001: m0 = seg;
                3'b010: m1 = seg;
                3'b100: m2 = seg;
                default: ;
            endcase
            case (anode_nb)
                3'b001: n0 = seg_nb;
                3'b010: n1 = seg_nb;
                3'b100: n2 = seg_nb;
                default: ;
            endcase
        end
    endtask

    function automatic logic [2:0] an_sel(input int w);
        return (w == 0) ? anode : anode_s1;
    endfunction

    task automatic check_scan(input int w, input int div, input string nm);
        logic [2:0] prev;
        int run;
        int guard;
        prev  = an_sel(w);
        guard = 0;
        while (an_sel(w) == prev && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({nm, " sync"}, 32'(guard < 20), 32'd1);
        for (int k = 0; k < 4; k++) begin
            prev = an_sel(w);
            run  = 0;
            while (an_sel(w) == prev && run < 20) begin
                @(negedge clk);
                run++;
            end
            check({nm, " slot length"}, 32'(run), 32'(div));
            check({nm, " slot order"}, 32'(an_sel(w)), 32'({prev[1:0], prev[2]}));
        end
    endtask

    initial begin
        logic [6:0] m0, m1, m2, n0, n1, n2;
        int nb, early, bs, guard;

        vecs[0]  = '{8'hFF, 12'h255, 7'h6D, 7'h6D, 7'h5B, 7'h6D, 7'h6D, 7'h5B};
        vecs[1]  = '{8'h07, 12'h007, 7'h07, 7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F};
        vecs[2]  = '{8'h0A, 12'h010, 7'h3F, 7'h06, 7'h00, 7'h3F, 7'h06, 7'h3F};
        vecs[3]  = '{8'h64, 12'h100, 7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h06};
        vecs[4]  = '{8'hC8, 12'h200, 7'h3F, 7'h3F, 7'h5B, 7'h3F, 7'h3F, 7'h5B};
        vecs[5]  = '{8'h2D, 12'h045, 7'h6D, 7'h66, 7'h00, 7'h6D, 7'h66, 7'h3F};
        vecs[6]  = '{8'h99, 12'h153, 7'h4F, 7'h6D, 7'h06, 7'h4F, 7'h6D, 7'h06};
        vecs[7]  = '{8'h80, 12'h128, 7'h7F, 7'h5B, 7'h06, 7'h7F, 7'h5B, 7'h06};
        vecs[8]  = '{8'h63, 12'h099, 7'h6F, 7'h6F, 7'h00, 7'h6F, 7'h6F, 7'h3F};
        vecs[9]  = '{8'h22, 12'h034, 7'h66, 7'h4F, 7'h00, 7'h66, 7'h4F, 7'h3F};
        vecs[10] = '{8'h10, 12'h016, 7'h7D, 7'h06, 7'h00, 7'h7D, 7'h06, 7'h3F};

        // Reset state, asserted asynchronously before any clock edge.
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset bcd", 32'(bcd), 32'h000);
        check("reset anode", 32'(anode), 32'b001);
        check("reset seg", 32'(seg), 32'h3F);
        repeat (3) @(negedge clk);
        clr = 1'b0;

        capture_frame(m0, m1, m2, n0, n1, n2, bs);
        check("idle zero no busy", 32'(bs), 32'd0);
        check("idle zero bcd", 32'(bcd), 32'h000);
        check("idle zero ones", 32'(m0), 32'h3F);
        check("idle zero tens blank", 32'(m1), 32'h00);
        check("idle zero hund blank", 32'(m2), 32'h00);
        check("idle zero nb tens", 32'(n1), 32'h3F);

        foreach (vecs[i]) begin
            $display("vector value=%0h expect bcd=%0h", vecs[i].v, vecs[i].b);
            convert(vecs[i].v, nb, early);
            check("busy cycles", 32'(nb), 32'd8);
            check("no early bcd update", 32'(early), 32'd0);
            check("bcd", 32'(bcd), 32'(vecs[i].b));
            check("bcd nb", 32'(bcd_nb), 32'(vecs[i].b));
            check("bcd s1", 32'(bcd_s1), 32'(vecs[i].b));
            capture_frame(m0, m1, m2, n0, n1, n2, bs);
            check("seg ones", 32'(m0), 32'(vecs[i].s0));
            check("seg tens", 32'(m1), 32'(vecs[i].s1));
            check("seg hund", 32'(m2), 32'(vecs[i].s2));
            check("nb seg ones", 32'(n0), 32'(vecs[i].n0));
            check("nb seg tens", 32'(n1), 32'(vecs[i].n1));
            check("nb seg hund", 32'(n2), 32'(vecs[i].n2));
        end

        // Change during conversion is ignored until the next IDLE compare.
        value = 8'h0A;
        @(negedge clk);
        check("midchg busy rises", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        value = 8'h64;
        nb = 3;
        while (busy && nb < 20) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("midchg first busy cycles", 32'(nb), 32'd8);
        check("midchg first bcd", 32'(bcd), 32'h010);
        @(negedge clk);
        check("midchg restart busy", 32'(busy), 32'd1);
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            @(negedge clk);
        end
        check("midchg second busy cycles", 32'(nb), 32'd8);
        check("midchg second bcd", 32'(bcd), 32'h100);

        // Abort by clr in the 5th conversion cycle.
        value = 8'hC8;
        repeat (5) @(negedge clk);
        check("abort busy before clr", 32'(busy), 32'd1);
        clr = 1'b1;
        #1;
        check("abort bcd cleared", 32'(bcd), 32'h000);
        check("abort busy", 32'(busy), 32'd0);
        check("abort anode", 32'(anode), 32'b001);
        check("abort seg", 32'(seg), 32'h3F);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("reconv busy", 32'(busy), 32'd1);
        check("reconv no stale bcd", 32'(bcd), 32'h000);
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            @(negedge clk);
        end
        check("reconv busy cycles", 32'(nb), 32'd8);
        check("reconv bcd", 32'(bcd), 32'h200);

        // Scan timing with value held.
        check_scan(0, 4, "scan div4");
        check_scan(1, 1, "scan div1");
        check("s1 idle", 32'(busy_s1), 32'd0);
        guard = 0;
        while (anode_s1 != 3'b001 && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        check("s1 ones seg", 32'(seg_s1), 32'h3F);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
